// File: rtl/stepper_seq_if.sv
// Command/status bundle for stepper_seq: move request inputs and coil/status outputs.
interface stepper_seq_if #(
    parameter int unsigned STEP_W = 16
);
    logic              i_start;
    logic              i_stop;
    logic [STEP_W-1:0] i_steps;
    logic              i_dir;
    logic              i_half_step;
    logic [3:0]        o_phase;
    logic              o_busy;
    logic              o_done;
    logic              o_aborted;
    logic [STEP_W-1:0] o_position;

    modport master (
        output i_start, i_stop, i_steps, i_dir, i_half_step,
        input  o_phase, o_busy, o_done, o_aborted, o_position
    );

    modport slave (
        input  i_start, i_stop, i_steps, i_dir, i_half_step,
        output o_phase, o_busy, o_done, o_aborted, o_position
    );
endinterface

// File: rtl/stepper_seq.sv
// Stepper phase sequencer fed by the fd divided clock (sampled as data, never used as a clock).
// Optional STEPPER_HOLD_TORQUE_EN keeps the coils energized outside RUN.
module stepper_seq #(
    parameter int unsigned TICKS_PER_STEP = 100,
    parameter int unsigned STEP_W         = 16
) (
    input  logic          i_clk_50MHz,
    input  logic          i_rst_n,
    input  logic          i_tick_clk,
    stepper_seq_if.slave  bus
);
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    localparam logic [15:0]       LP_LAST = 16'(TICKS_PER_STEP - 1);
    localparam logic [STEP_W-1:0] LP_ONE  = STEP_W'(1);

    state_t            r_state, w_next;
    logic              r_s1, r_s2, r_s3;
    logic [15:0]       r_presc;
    logic [STEP_W-1:0] r_remaining;
    logic [STEP_W-1:0] r_position;
    logic [2:0]        r_idx;
    logic              r_dir, r_half, r_aborted;
    logic              w_tick, w_accept, w_step;
    logic [2:0]        w_delta;
    logic [3:0]        w_table;

    function automatic logic [3:0] phase_of(input logic [2:0] idx);
        case (idx)
            3'd0:    phase_of = 4'b1000;
            3'd1:    phase_of = 4'b1100;
            3'd2:    phase_of = 4'b0100;
            3'd3:    phase_of = 4'b0110;
            3'd4:    phase_of = 4'b0010;
            3'd5:    phase_of = 4'b0011;
            3'd6:    phase_of = 4'b0001;
            default: phase_of = 4'b1001;
        endcase
    endfunction

    assign w_tick   = r_s2 & ~r_s3;
    assign w_accept = (r_state == S_IDLE) & bus.i_start;
    // stop outranks a coincident tick, so a step only fires when stop is low
    assign w_step   = (r_state == S_RUN) & ~bus.i_stop & w_tick & (r_presc == LP_LAST);
    assign w_delta  = r_half ? 3'd1 : 3'd2;

    always_ff @(posedge i_clk_50MHz) begin
        if (!i_rst_n) r_state <= S_IDLE;
        else          r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: if (bus.i_start) w_next = (bus.i_steps == '0) ? S_DONE : S_RUN;
            S_RUN: begin
                if (bus.i_stop)                              w_next = S_DONE;
                else if (w_step && r_remaining == LP_ONE)    w_next = S_DONE;
            end
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk_50MHz) begin
        if (!i_rst_n) begin
            r_s1        <= 1'b0;
            r_s2        <= 1'b0;
            r_s3        <= 1'b0;
            r_presc     <= '0;
            r_remaining <= '0;
            r_position  <= '0;
            r_idx       <= '0;
            r_dir       <= 1'b0;
            r_half      <= 1'b0;
            r_aborted   <= 1'b0;
        end else begin
            r_s1 <= i_tick_clk;
            r_s2 <= r_s1;
            r_s3 <= r_s2;
            if (w_accept) begin
                r_remaining <= bus.i_steps;
                r_dir       <= bus.i_dir;
                r_half      <= bus.i_half_step;
                r_presc     <= '0;
                r_aborted   <= 1'b0;
                // full-step drive uses the two-coil (odd) entries only
                if (!bus.i_half_step) r_idx <= r_idx | 3'd1;
            end else if (r_state == S_RUN) begin
                if (bus.i_stop) begin
                    r_aborted <= 1'b1;
                end else if (w_tick) begin
                    if (r_presc == LP_LAST) begin
                        r_presc     <= '0;
                        r_remaining <= r_remaining - LP_ONE;
                        r_idx       <= r_dir ? r_idx + w_delta : r_idx - w_delta;
                        r_position  <= r_dir ? r_position + LP_ONE : r_position - LP_ONE;
                    end else begin
                        r_presc <= r_presc + 16'd1;
                    end
                end
            end
        end
    end

    always_comb begin
        w_table        = phase_of(r_idx);
        bus.o_busy     = (r_state == S_RUN);
        bus.o_done     = (r_state == S_DONE);
        bus.o_aborted  = r_aborted;
        bus.o_position = r_position;
`ifdef STEPPER_HOLD_TORQUE_EN
        bus.o_phase    = w_table;
`else
        bus.o_phase    = (r_state == S_RUN) ? w_table : 4'b0000;
`endif
    end
endmodule

// File: tb/tb_stepper_seq.sv
// Directed bench for stepper_seq with a cycle-level behavioural model checked every cycle.
module tb_stepper_seq;
    localparam int T = 2;

`ifdef STEPPER_HOLD_TORQUE_EN
    localparam bit HOLD = 1'b1;
`else
    localparam bit HOLD = 1'b0;
`endif

    logic clk, rst_n, tick_clk;
    int   errors = 0;
    int   checks = 0;
    bit   cmp_en = 1'b0;

    stepper_seq_if #(.STEP_W(16)) bus ();

    stepper_seq #(.TICKS_PER_STEP(T), .STEP_W(16)) dut (
        .i_clk_50MHz (clk),
        .i_rst_n     (rst_n),
        .i_tick_clk  (tick_clk),
        .bus         (bus)
    );

    initial begin
        clk = 1'b0;
        forever #10 clk = ~clk;
    end

    // 100 kHz, edges offset 5 ns before a clk rising edge
    initial begin
        tick_clk = 1'b0;
        #5005;
        forever #5000 tick_clk = ~tick_clk;
    end

    logic [3:0] tbl [8] = '{4'b1000, 4'b1100, 4'b0100, 4'b0110,
                            4'b0010, 4'b0011, 4'b0001, 4'b1001};

    // Model: raw tick samples are taken each edge; a rising pair becomes a tick two edges later.
    bit          m_busy, m_done, m_ab, m_dir, m_half;
    bit          m_h1, m_h2, m_h3, m_tk;
    logic [15:0] m_pos;
    int          m_idx, m_cnt, m_left, m_taken;

    always @(posedge clk) begin
        m_tk = m_h2 && !m_h3;
        if (!rst_n) begin
            m_busy = 0; m_done = 0; m_ab = 0; m_pos = '0; m_idx = 0; m_cnt = 0;
            m_left = 0; m_taken = 0; m_h1 = 0; m_h2 = 0; m_h3 = 0;
        end else begin
            if (m_done) begin
                m_done = 0;
            end else if (m_busy) begin
                if (bus.i_stop) begin
                    m_busy = 0; m_done = 1; m_ab = 1;
                end else if (m_tk) begin
                    m_cnt++;
                    if (m_cnt == T) begin
                        m_cnt = 0;
                        m_pos = m_dir ? m_pos + 16'd1 : m_pos - 16'd1;
                        m_idx = (m_idx + (m_dir ? (m_half ? 1 : 2) : (m_half ? 7 : 6))) % 8;
                        m_left--;
                        m_taken++;
                        if (m_left == 0) begin m_busy = 0; m_done = 1; end
                    end
                end
            end else if (bus.i_start) begin
                m_left = int'(bus.i_steps); m_dir = bus.i_dir; m_half = bus.i_half_step;
                m_cnt = 0; m_ab = 0; m_taken = 0;
                if (!m_half) m_idx = m_idx | 1;
                if (m_left == 0) m_done = 1; else m_busy = 1;
            end
            m_h3 = m_h2; m_h2 = m_h1; m_h1 = tick_clk;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    logic [3:0] rec[$];

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("phase", {28'd0, bus.o_phase}, {28'd0, (HOLD || m_busy) ? tbl[m_idx] : 4'b0000});
            chk("busy", {31'd0, bus.o_busy}, {31'd0, m_busy});
            chk("done", {31'd0, bus.o_done}, {31'd0, m_done});
            chk("aborted", {31'd0, bus.o_aborted}, {31'd0, m_ab});
            chk("position", {16'd0, bus.o_position}, {16'd0, m_pos});
            if (bus.o_busy && (rec.size() == 0 || rec[$] != bus.o_phase))
                rec.push_back(bus.o_phase);
        end
    end

    task automatic start_move(input int steps, input bit dir, input bit half);
        @(negedge clk);
        bus.i_steps = 16'(steps); bus.i_dir = dir; bus.i_half_step = half; bus.i_start = 1'b1;
        @(negedge clk);
        bus.i_start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int k = 0;
        while (!bus.o_done && k < budget) begin
            @(negedge clk);
            k++;
        end
        chk("done_within_budget", {31'd0, bus.o_done}, 32'd1);
    endtask

    logic [3:0] cw_exp [4] = '{4'b1100, 4'b0110, 4'b0011, 4'b1001};
    logic [3:0] hc_exp [3] = '{4'b1000, 4'b1001, 4'b0001};
    logic [15:0] p_before;

    initial begin
        rst_n = 1'b0;
        bus.i_start = 0; bus.i_stop = 0; bus.i_steps = '0; bus.i_dir = 0; bus.i_half_step = 0;
        repeat (3) @(negedge clk);
        cmp_en = 1'b1;
        chk("reset_phase", {28'd0, bus.o_phase}, {28'd0, HOLD ? 4'b1000 : 4'b0000});
        rst_n = 1'b1;

        // reset in the middle of a move
        start_move(4, 1'b1, 1'b0);
        repeat (1500) @(negedge clk);
        chk("busy_before_reset", {31'd0, bus.o_busy}, 32'd1);
        rst_n = 1'b0;
        repeat (5) @(negedge clk);
        chk("rst_busy", {31'd0, bus.o_busy}, 32'd0);
        chk("rst_done", {31'd0, bus.o_done}, 32'd0);
        chk("rst_aborted", {31'd0, bus.o_aborted}, 32'd0);
        chk("rst_position", {16'd0, bus.o_position}, 32'd0);
        chk("rst_phase", {28'd0, bus.o_phase}, {28'd0, HOLD ? 4'b1000 : 4'b0000});
        rst_n = 1'b1;

        // full-step CW, 4 steps
        rec.delete();
        start_move(4, 1'b1, 1'b0);
        wait_done(10000);
        chk("cw_position", {16'd0, bus.o_position}, 32'd4);
        chk("cw_aborted", {31'd0, bus.o_aborted}, 32'd0);
        chk("cw_final_phase", {28'd0, bus.o_phase}, {28'd0, HOLD ? 4'b1100 : 4'b0000});
        chk("cw_seq_len", rec.size(), 32'd4);
        for (int i = 0; i < 4; i++)
            chk("cw_seq", {28'd0, (i < rec.size()) ? rec[i] : 4'hx}, {28'd0, cw_exp[i]});
        @(negedge clk);
        chk("cw_done_one_cycle", {31'd0, bus.o_done}, 32'd0);

        // half-step CCW, 3 steps from idx 0
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        rec.delete();
        start_move(3, 1'b0, 1'b1);
        wait_done(10000);
        chk("ccw_position", {16'd0, bus.o_position}, 32'h0000FFFD);
        chk("ccw_final_phase", {28'd0, bus.o_phase}, {28'd0, HOLD ? 4'b0011 : 4'b0000});
        chk("ccw_seq_len", rec.size(), 32'd3);
        for (int i = 0; i < 3; i++)
            chk("ccw_seq", {28'd0, (i < rec.size()) ? rec[i] : 4'hx}, {28'd0, hc_exp[i]});

        // abort on the tick that would have produced step 6
        start_move(100, 1'b1, 1'b0);
        begin
            int k = 0;
            while (!(m_busy && m_taken == 5 && m_cnt == T - 1 && m_h2 && !m_h3) && k < 20000) begin
                @(negedge clk);
                k++;
            end
            chk("abort_window_found", {31'd0, (k < 20000)}, 32'd1);
        end
        bus.i_stop = 1'b1;
        @(negedge clk);
        bus.i_stop = 1'b0;
        chk("abort_done", {31'd0, bus.o_done}, 32'd1);
        chk("abort_flag", {31'd0, bus.o_aborted}, 32'd1);
        chk("abort_position", {16'd0, bus.o_position}, 32'h00000002);
        repeat (3) @(negedge clk);

        // zero-step move with start held into DONE; stop in IDLE ignored
        bus.i_steps = '0; bus.i_start = 1'b1;
        @(negedge clk);
        chk("zero_done", {31'd0, bus.o_done}, 32'd1);
        chk("zero_aborted_cleared", {31'd0, bus.o_aborted}, 32'd0);
        chk("zero_busy", {31'd0, bus.o_busy}, 32'd0);
        @(negedge clk);
        bus.i_start = 1'b0;
        chk("zero_done_single", {31'd0, bus.o_done}, 32'd0);
        bus.i_stop = 1'b1;
        @(negedge clk);
        bus.i_stop = 1'b0;
        chk("zero_idle_busy", {31'd0, bus.o_busy}, 32'd0);
        chk("zero_position", {16'd0, bus.o_position}, 32'h00000002);

        // mid-move start/dir/mode changes ignored, plus tick-to-step latency
        start_move(6, 1'b1, 1'b1);
        repeat (700) @(negedge clk);
        bus.i_steps = 16'd50; bus.i_dir = 1'b0; bus.i_half_step = 1'b0; bus.i_start = 1'b1;
        @(negedge clk);
        bus.i_start = 1'b0;
        begin
            int k = 0;
            while (!(m_busy && m_cnt == T - 1 && !tick_clk) && k < 5000) begin
                @(negedge clk);
                k++;
            end
            chk("latency_window_found", {31'd0, (k < 5000)}, 32'd1);
        end
        p_before = m_pos;
        @(posedge tick_clk);
        @(posedge clk);
        @(negedge clk);
        chk("latency_edge1", {16'd0, bus.o_position}, {16'd0, p_before});
        @(posedge clk);
        @(negedge clk);
        chk("latency_edge2", {16'd0, bus.o_position}, {16'd0, p_before});
        @(posedge clk);
        @(negedge clk);
        chk("latency_edge3", {16'd0, bus.o_position}, {16'd0, p_before + 16'd1});
        wait_done(10000);
        chk("ignore_position", {16'd0, bus.o_position}, 32'h00000008);
        repeat (3) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
